// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - PID codes (NRZI line-image encoding), scheduler states and PID classifiers.
package usb_pkg;

   typedef enum logic [7:0] {
      PID_OUT   = 8'hF5,
      PID_IN    = 8'h8D,
      PID_SOF   = 8'hC9,
      PID_SETUP = 8'hB1,
      PID_DATA0 = 8'hEB,
      PID_DATA1 = 8'h93,
      PID_DATA2 = 8'hD7,
      PID_MDATA = 8'hAF,
      PID_ACK   = 8'hE4,
      PID_NAK   = 8'h9C,
      PID_STALL = 8'hA0,
      PID_NYET  = 8'hD8,
      PID_PRE   = 8'hBE,
      PID_SPLIT = 8'h82,
      PID_PING  = 8'hC6
   } pid_t;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_H_PKT    = 3'd1,
      S_D_PKT    = 3'd2,
      S_HOLD     = 3'd3,
      S_DEV_WAIT = 3'd4
   } sched_state_t;

   function automatic bit is_token(input logic [7:0] p);
      return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) || (p == PID_SETUP);
   endfunction

   function automatic bit is_data(input logic [7:0] p);
      return (p == PID_DATA0) || (p == PID_DATA1) || (p == PID_DATA2) || (p == PID_MDATA);
   endfunction

   function automatic bit is_handshake(input logic [7:0] p);
      return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL) || (p == PID_NYET);
   endfunction

   function automatic bit is_valid_pid(input logic [7:0] p);
      return is_token(p) || is_data(p) || is_handshake(p) ||
             (p == PID_PRE) || (p == PID_SPLIT) || (p == PID_PING);
   endfunction

endpackage

// File: rtl/usb_turnaround_timer.sv
// rtl/usb_turnaround_timer.sv - loadable down-counter; expired_o flags a zero count while enabled.
module usb_turnaround_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Combinational so the owner can load a new interval on the expiry cycle.
   assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/usb_dir_sched.sv
// rtl/usb_dir_sched.sv - USB repeater direction scheduler; optional stats via USB_DIR_SCHED_STATS_EN.
module usb_dir_sched
   import usb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 72,
   parameter int EOP_HOLD       = 2,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             proxy_en,
   input  logic             host_sop,
   input  logic             dev_sop,
   input  logic             pid_valid,
   input  logic [7:0]       pid,
   input  logic             eop,
   output logic             host_dir,
   output logic             device_dir,
   output logic [2:0]       state,
   output logic             timeout,
   output logic             pid_err,
   output logic [CNT_W-1:0] timeout_cnt,
   output logic [CNT_W-1:0] txn_cnt
);

   localparam int MAXV = (TIMEOUT_CYCLES > EOP_HOLD) ? TIMEOUT_CYCLES : EOP_HOLD;
   localparam int TW   = $clog2(MAXV + 1);
   localparam logic [TW-1:0] HOLD_LD = TW'(EOP_HOLD - 1);
   localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_CYCLES - 1);

   sched_state_t state_q, state_d;
   logic         host_dir_q, host_dir_d, device_dir_q, device_dir_d;
   logic         timeout_q, timeout_d, pid_err_q, pid_err_d;
   logic [7:0]   cur_pid_q, cur_pid_d, prev_pid_q, prev_pid_d;
   logic         pid_seen_q, pid_seen_d, from_dev_q, from_dev_d;
   logic         tmr_load, tmr_en, tmr_exp;
   logic [TW-1:0] tmr_val;

   usb_turnaround_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .expired_o  (tmr_exp)
   );

   always_comb begin
      state_d      = state_q;
      host_dir_d   = host_dir_q;
      device_dir_d = device_dir_q;
      cur_pid_d    = cur_pid_q;
      prev_pid_d   = prev_pid_q;
      pid_seen_d   = pid_seen_q;
      from_dev_d   = from_dev_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      tmr_en       = 1'b0;
      timeout_d    = 1'b0;
      pid_err_d    = pid_valid && !is_valid_pid(pid);

      case (state_q)
         S_IDLE: begin
            if (host_sop) begin
               state_d    = S_H_PKT;
               pid_seen_d = 1'b0;
               from_dev_d = 1'b0;
            end
         end
         S_H_PKT, S_D_PKT: begin
            if (pid_valid) begin
               cur_pid_d  = pid;
               pid_seen_d = 1'b1;
            end
            if (eop) begin
               state_d  = S_HOLD;
               tmr_load = 1'b1;
               tmr_val  = HOLD_LD;
            end
         end
         S_HOLD: begin
            tmr_en = 1'b1;
            if (tmr_exp) begin
               state_d = S_IDLE;
               // A packet whose PID never decoded does not advance the transaction phase.
               if (pid_seen_q) begin
                  prev_pid_d = cur_pid_q;
                  if (!from_dev_q && ((cur_pid_q == PID_IN) ||
                      (is_data(cur_pid_q) && ((prev_pid_q == PID_OUT) || (prev_pid_q == PID_SETUP))))) begin
                     state_d  = S_DEV_WAIT;
                     tmr_load = 1'b1;
                     tmr_val  = TO_LD;
                  end
               end
            end
         end
         S_DEV_WAIT: begin
            tmr_en = 1'b1;
            if (host_sop) begin
               state_d    = S_H_PKT;
               pid_seen_d = 1'b0;
               from_dev_d = 1'b0;
            end else if (dev_sop) begin
               state_d    = S_D_PKT;
               pid_seen_d = 1'b0;
               from_dev_d = 1'b1;
            end else if (tmr_exp) begin
               state_d   = S_IDLE;
               timeout_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_IDLE, S_H_PKT: begin host_dir_d = 1'b1; device_dir_d = 1'b0; end
         S_D_PKT:         begin host_dir_d = 1'b0; device_dir_d = 1'b1; end
         S_DEV_WAIT:      begin host_dir_d = 1'b1; device_dir_d = 1'b1; end
         default:         ;
      endcase

      if (!proxy_en) begin
         state_d      = S_IDLE;
         host_dir_d   = 1'b1;
         device_dir_d = 1'b0;
         tmr_load     = 1'b1;
         tmr_val      = '0;
         timeout_d    = 1'b0;
         pid_err_d    = 1'b0;
         pid_seen_d   = 1'b0;
         from_dev_d   = 1'b0;
         cur_pid_d    = '0;
         prev_pid_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         host_dir_q   <= 1'b1;
         device_dir_q <= 1'b0;
         timeout_q    <= 1'b0;
         pid_err_q    <= 1'b0;
         cur_pid_q    <= '0;
         prev_pid_q   <= '0;
         pid_seen_q   <= 1'b0;
         from_dev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         host_dir_q   <= host_dir_d;
         device_dir_q <= device_dir_d;
         timeout_q    <= timeout_d;
         pid_err_q    <= pid_err_d;
         cur_pid_q    <= cur_pid_d;
         prev_pid_q   <= prev_pid_d;
         pid_seen_q   <= pid_seen_d;
         from_dev_q   <= from_dev_d;
      end
   end

   assign host_dir   = host_dir_q;
   assign device_dir = device_dir_q;
   assign state      = state_q;
   assign timeout    = timeout_q;
   assign pid_err    = pid_err_q;

`ifdef USB_DIR_SCHED_STATS_EN
   logic [CNT_W-1:0] txn_cnt_q, timeout_cnt_q;
   logic             txn_inc;

   assign txn_inc = proxy_en && (state_q == S_HOLD) && tmr_exp && pid_seen_q &&
                    from_dev_q && is_handshake(cur_pid_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         txn_cnt_q     <= '0;
         timeout_cnt_q <= '0;
      end else begin
         if (txn_inc && (txn_cnt_q != '1))
            txn_cnt_q <= txn_cnt_q + CNT_W'(1);
         if (timeout_q && (timeout_cnt_q != '1))
            timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
      end
   end

   assign txn_cnt     = txn_cnt_q;
   assign timeout_cnt = timeout_cnt_q;
`else
   assign txn_cnt     = '0;
   assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_usb_dir_sched.sv
// tb/tb_usb_dir_sched.sv - directed self-checking bench for usb_dir_sched.
module tb_usb_dir_sched;

   localparam logic [7:0] P_OUT   = 8'hF5;
   localparam logic [7:0] P_IN    = 8'h8D;
   localparam logic [7:0] P_DATA0 = 8'hEB;
   localparam logic [7:0] P_DATA1 = 8'h93;
   localparam logic [7:0] P_ACK   = 8'hE4;
   localparam logic [7:0] P_BAD   = 8'h00;

`ifdef USB_DIR_SCHED_STATS_EN
   localparam int STAT_ONE = 1;
`else
   localparam int STAT_ONE = 0;
`endif

   logic        clk = 1'b0;
   logic        rst, proxy_en, host_sop, dev_sop, pid_valid, eop;
   logic [7:0]  pid;
   logic        host_dir, device_dir, timeout, pid_err;
   logic [2:0]  state;
   logic [15:0] timeout_cnt, txn_cnt;

   int n_cmp = 0;
   int n_err = 0;

   usb_dir_sched dut (
      .clk         (clk),
      .rst         (rst),
      .proxy_en    (proxy_en),
      .host_sop    (host_sop),
      .dev_sop     (dev_sop),
      .pid_valid   (pid_valid),
      .pid         (pid),
      .eop         (eop),
      .host_dir    (host_dir),
      .device_dir  (device_dir),
      .state       (state),
      .timeout     (timeout),
      .pid_err     (pid_err),
      .timeout_cnt (timeout_cnt),
      .txn_cnt     (txn_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_dir(input string tag, input logic [2:0] st, input logic h, input logic d);
      check({tag, ".state"}, 32'(state), 32'(st));
      check({tag, ".h"}, 32'(host_dir), 32'(h));
      check({tag, ".d"}, 32'(device_dir), 32'(d));
   endtask

   // One packet: sop, optional PID, eop. Leaves the DUT in its first HOLD cycle.
   task automatic send_pkt(input bit from_dev, input logic [7:0] p, input bit with_pid);
      if (from_dev) dev_sop = 1'b1; else host_sop = 1'b1;
      tick();
      host_sop = 1'b0; dev_sop = 1'b0;
      if (with_pid) begin
         pid = p; pid_valid = 1'b1;
         tick();
         pid_valid = 1'b0;
      end
      eop = 1'b1;
      tick();
      eop = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; proxy_en = 1'b1; host_sop = 1'b0; dev_sop = 1'b0;
      pid_valid = 1'b0; pid = 8'h00; eop = 1'b0;
      tick(); tick();
      check_dir("reset", 3'd0, 1'b1, 1'b0);
      check("reset.timeout", 32'(timeout), 32'd0);
      check("reset.pid_err", 32'(pid_err), 32'd0);
      check("reset.txn_cnt", 32'(txn_cnt), 32'd0);
      check("reset.timeout_cnt", 32'(timeout_cnt), 32'd0);
      rst = 1'b0;

      // dev_sop while idle is not a transaction start
      dev_sop = 1'b1; tick(); dev_sop = 1'b0;
      check_dir("idle_devsop", 3'd0, 1'b1, 1'b0);

      // IN transaction with a stray sop during HOLD
      send_pkt(1'b0, P_IN, 1'b1);
      check_dir("in.hold1", 3'd3, 1'b1, 1'b0);
      dev_sop = 1'b1; host_sop = 1'b1; tick(); dev_sop = 1'b0; host_sop = 1'b0;
      check_dir("in.hold2", 3'd3, 1'b1, 1'b0);
      tick();
      check_dir("in.devwait", 3'd4, 1'b1, 1'b1);
      dev_sop = 1'b1; tick(); dev_sop = 1'b0;
      check_dir("in.dpkt", 3'd2, 1'b0, 1'b1);
      pid = P_DATA1; pid_valid = 1'b1; tick(); pid_valid = 1'b0;
      eop = 1'b1; tick(); eop = 1'b0;
      check_dir("in.dhold", 3'd3, 1'b0, 1'b1);
      tick(); tick();
      check_dir("in.done", 3'd0, 1'b1, 1'b0);

      // OUT transaction: token, data, device ACK
      send_pkt(1'b0, P_OUT, 1'b1); tick(); tick();
      check_dir("out.token", 3'd0, 1'b1, 1'b0);
      send_pkt(1'b0, P_DATA0, 1'b1); tick(); tick();
      check_dir("out.data", 3'd4, 1'b1, 1'b1);
      send_pkt(1'b1, P_ACK, 1'b1); tick(); tick();
      check_dir("out.ack", 3'd0, 1'b1, 1'b0);
      check("out.txn_cnt", 32'(txn_cnt), 32'(STAT_ONE));

      // Turnaround timeout
      send_pkt(1'b0, P_IN, 1'b1); tick(); tick();
      check("to.entry", 32'(state), 32'd4);
      n = 1;
      while (state == 3'd4 && n < 200) begin
         check("to.no_early_pulse", 32'(timeout), 32'd0);
         tick();
         if (state == 3'd4) n++;
      end
      check("to.cycles", 32'(n), 32'd72);
      check("to.pulse", 32'(timeout), 32'd1);
      check_dir("to.idle", 3'd0, 1'b1, 1'b0);
      tick();
      check("to.pulse_end", 32'(timeout), 32'd0);
      check("to.timeout_cnt", 32'(timeout_cnt), 32'(STAT_ONE));

      // Same-cycle tie in DEV_WAIT, then an eop with no PID must not re-open the IN phase
      send_pkt(1'b0, P_IN, 1'b1); tick(); tick();
      host_sop = 1'b1; dev_sop = 1'b1; tick(); host_sop = 1'b0; dev_sop = 1'b0;
      check_dir("tie", 3'd1, 1'b1, 1'b0);
      eop = 1'b1; tick(); eop = 1'b0; tick(); tick();
      check_dir("nopid", 3'd0, 1'b1, 1'b0);

      // Unknown PID
      host_sop = 1'b1; tick(); host_sop = 1'b0;
      pid = P_BAD; pid_valid = 1'b1; tick(); pid_valid = 1'b0;
      check("bad.pid_err", 32'(pid_err), 32'd1);
      check("bad.state", 32'(state), 32'd1);
      tick();
      check("bad.pid_err_end", 32'(pid_err), 32'd0);
      eop = 1'b1; tick(); eop = 1'b0; tick(); tick();
      check("bad.idle", 32'(state), 32'd0);

      // proxy_en drop during a device packet
      send_pkt(1'b0, P_IN, 1'b1); tick(); tick();
      dev_sop = 1'b1; tick(); dev_sop = 1'b0;
      check("abort.dpkt", 32'(state), 32'd2);
      proxy_en = 1'b0; tick();
      check_dir("abort", 3'd0, 1'b1, 1'b0);
      proxy_en = 1'b1;

      // rst in the middle of DEV_WAIT
      send_pkt(1'b0, P_IN, 1'b1); tick(); tick();
      tick(); tick(); tick();
      check("rst.devwait", 32'(state), 32'd4);
      rst = 1'b1; tick(); rst = 1'b0;
      check_dir("rst", 3'd0, 1'b1, 1'b0);
      check("rst.timeout", 32'(timeout), 32'd0);
      check("rst.txn_cnt", 32'(txn_cnt), 32'd0);
      tick(); tick();
      check("rst.stay_idle", 32'(state), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
